// File: rtl/gfx_rom_arbiter.sv
// ---------------------------------------------------------------------------
// gfx_rom_arbiter
//
// Shares one 32-bit external ROM read port (SDRAM controller side) between
// three requesters: tile fetch (planes), sprite fetch and theme-tune
// playback (audio). Misses are arbitrated with fixed priority
// tile > sprite > theme. Theme is forced to the front once it has lost
// THEME_MAX_WAIT grants in a row. Each requester keeps a one-word hit
// latch (last address + data) so a repeat fetch of the same word is
// answered locally without touching memory.
//
// Ports
//   clk_sys          system clock (96 MHz)
//   reset            asynchronous, active-high reset
//   ioctl_download   ROM load in progress: clears hit latches, holds grants
//   tile_req/addr    tile level request + word-32 address (18 bit)
//   tile_ack/dout    one-cycle ack, data held until the next ack
//   spr_req/addr     sprite level request + word-32 address (19 bit)
//   spr_ack/dout     one-cycle ack, data held until the next ack
//   theme_req/addr   theme level request + word-16 address (18 bit)
//   theme_ack/dout   one-cycle ack, selected 16-bit halfword
//   mem_req/addr     external read request (held until mem_ready) + address
//   mem_ready/dout   one-cycle completion pulse with read data
//
// Optional build macro GFXARB_STATS_EN adds:
//   stat_miss[47:0]  miss-grant counts  {theme, sprite, tile} x 16 bit
//   stat_hit[47:0]   hit-ack counts     {theme, sprite, tile} x 16 bit
//   stat_maxlat      largest tile req-to-ack time in cycles (saturating)
// ---------------------------------------------------------------------------
module gfx_rom_arbiter #(
  parameter logic [21:0] TILE_BASE      = 22'h000000,
  parameter logic [21:0] SPR_BASE       = 22'h040000,
  parameter logic [21:0] THEME_BASE     = 22'h0C0000,
  parameter int unsigned THEME_MAX_WAIT = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,

  input  logic        tile_req,
  input  logic [17:0] tile_addr,
  output logic        tile_ack,
  output logic [31:0] tile_dout,

  input  logic        spr_req,
  input  logic [18:0] spr_addr,
  output logic        spr_ack,
  output logic [31:0] spr_dout,

  input  logic        theme_req,
  input  logic [17:0] theme_addr,
  output logic        theme_ack,
  output logic [15:0] theme_dout,

`ifdef GFXARB_STATS_EN
  output logic [47:0] stat_miss,
  output logic [47:0] stat_hit,
  output logic [7:0]  stat_maxlat,
`endif

  output logic        mem_req,
  output logic [21:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    W_TILE,
    W_SPR,
    W_THEME
  } winner_t;

  localparam logic [7:0] MAX_WAIT = 8'(THEME_MAX_WAIT);

  state_t      state;
  winner_t     winner;
  logic [18:0] grant_addr;   // requester-side address of the transfer in flight

  // Hit latches: last fetched address, its data and a valid flag.
  logic [17:0] tile_last;
  logic        tile_valid;
  logic [18:0] spr_last;
  logic        spr_valid;
  logic [16:0] theme_last;   // word-32 address (theme_addr[17:1])
  logic [31:0] theme_word;   // full word, so either halfword can hit
  logic        theme_valid;

  logic [7:0]  theme_wait;   // grants lost by a pending theme miss

  // -------------------------------------------------------------------------
  // Hit / miss classification
  // -------------------------------------------------------------------------
  logic busy;
  logic tile_match, spr_match, theme_match;
  logic tile_hit,   spr_hit,   theme_hit;
  logic tile_miss,  spr_miss,  theme_miss;
  logic any_miss;

  assign busy        = (state != ST_IDLE);

  assign tile_match  = tile_valid  && (tile_addr == tile_last);
  assign spr_match   = spr_valid   && (spr_addr == spr_last);
  assign theme_match = theme_valid && (theme_addr[17:1] == theme_last);

  // A hit is suppressed while its own ack is high, so a requester that keeps
  // asking for the same word sees ack, gap, ack, gap, ...
  assign tile_hit  = tile_req  && tile_match  && !(busy && winner == W_TILE)  && !tile_ack;
  assign spr_hit   = spr_req   && spr_match   && !(busy && winner == W_SPR)   && !spr_ack;
  assign theme_hit = theme_req && theme_match && !(busy && winner == W_THEME) && !theme_ack;

  assign tile_miss  = tile_req  && !tile_match;
  assign spr_miss   = spr_req   && !spr_match;
  assign theme_miss = theme_req && !theme_match;
  assign any_miss   = tile_miss || spr_miss || theme_miss;

  // -------------------------------------------------------------------------
  // Arbitration among misses
  // -------------------------------------------------------------------------
  logic        grant_now;
  winner_t     pick;
  logic [21:0] pick_mem_addr;
  logic [18:0] pick_req_addr;

  assign grant_now = (state == ST_IDLE) && any_miss && !ioctl_download;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pick = W_THEME;
    if (theme_miss && (theme_wait >= MAX_WAIT)) begin
      pick = W_THEME;
    end else if (tile_miss) begin
      pick = W_TILE;
    end else if (spr_miss) begin
      pick = W_SPR;
    end
  end

  // Base-relative sums are 22 bits wide and wrap modulo 2^22.
  always_comb begin
    pick_mem_addr = THEME_BASE + {5'd0, theme_addr[17:1]};
    pick_req_addr = {1'b0, theme_addr};
    case (pick)
      W_TILE: begin
        pick_mem_addr = TILE_BASE + {4'd0, tile_addr};
        pick_req_addr = {1'b0, tile_addr};
      end
      W_SPR: begin
        pick_mem_addr = SPR_BASE + {3'd0, spr_addr};
        pick_req_addr = spr_addr;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM, hit latches and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the hit latches and data registers are ordinary flops here, so they
  // are all reset; outputs must read 0 straight out of reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      winner      <= W_TILE;
      grant_addr  <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      tile_ack    <= 1'b0;
      spr_ack     <= 1'b0;
      theme_ack   <= 1'b0;
      tile_dout   <= '0;
      spr_dout    <= '0;
      theme_dout  <= '0;
      tile_last   <= '0;
      tile_valid  <= 1'b0;
      spr_last    <= '0;
      spr_valid   <= 1'b0;
      theme_last  <= '0;
      theme_word  <= '0;
      theme_valid <= 1'b0;
      theme_wait  <= '0;
    end else begin
      // Hit acks; the DONE state may additionally raise the winner's ack.
      tile_ack  <= tile_hit;
      spr_ack   <= spr_hit;
      theme_ack <= theme_hit;
      if (theme_hit) begin
        theme_dout <= theme_addr[0] ? theme_word[31:16] : theme_word[15:0];
      end

      if (!theme_req) begin
        theme_wait <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            winner     <= pick;
            grant_addr <= pick_req_addr;
            mem_addr   <= pick_mem_addr;
            state      <= ST_GRANT;
            if (pick == W_THEME) begin
              theme_wait <= '0;
            end else if (theme_miss && theme_wait != 8'hFF) begin
              theme_wait <= theme_wait + 8'd1;
            end
          end
        end

        ST_GRANT: begin
          mem_req <= 1'b1;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ST_DONE;
            case (winner)
              W_TILE: begin
                tile_dout  <= mem_dout;
                tile_last  <= grant_addr[17:0];
                tile_valid <= 1'b1;
              end
              W_SPR: begin
                spr_dout  <= mem_dout;
                spr_last  <= grant_addr;
                spr_valid <= 1'b1;
              end
              default: begin
                theme_word  <= mem_dout;
                theme_dout  <= grant_addr[0] ? mem_dout[31:16] : mem_dout[15:0];
                theme_last  <= grant_addr[17:1];
                theme_valid <= 1'b1;
              end
            endcase
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          case (winner)
            W_TILE:  tile_ack  <= 1'b1;
            W_SPR:   spr_ack   <= 1'b1;
            default: theme_ack <= 1'b1;
          endcase
        end

        default: state <= ST_IDLE;
      endcase

      // A ROM load invalidates every latch; placed last so it also wins over
      // a capture that completes while the download is running.
      if (ioctl_download) begin
        tile_valid  <= 1'b0;
        spr_valid   <= 1'b0;
        theme_valid <= 1'b0;
      end
    end
  end

`ifdef GFXARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics counters (all saturating)
  // -------------------------------------------------------------------------
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0] tile_lat_cnt;   // cycles the current tile request has waited

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stat_miss    <= '0;
      stat_hit     <= '0;
      stat_maxlat  <= '0;
      tile_lat_cnt <= '0;
    end else begin
      if (grant_now) begin
        case (pick)
          W_TILE:  stat_miss[15:0]  <= sat_inc16(stat_miss[15:0]);
          W_SPR:   stat_miss[31:16] <= sat_inc16(stat_miss[31:16]);
          default: stat_miss[47:32] <= sat_inc16(stat_miss[47:32]);
        endcase
      end
      if (tile_hit)  stat_hit[15:0]  <= sat_inc16(stat_hit[15:0]);
      if (spr_hit)   stat_hit[31:16] <= sat_inc16(stat_hit[31:16]);
      if (theme_hit) stat_hit[47:32] <= sat_inc16(stat_hit[47:32]);

      if (tile_ack) begin
        if (tile_lat_cnt > stat_maxlat) begin
          stat_maxlat <= tile_lat_cnt;
        end
        tile_lat_cnt <= '0;
      end else if (tile_req) begin
        if (tile_lat_cnt != 8'hFF) begin
          tile_lat_cnt <= tile_lat_cnt + 8'd1;
        end
      end else begin
        tile_lat_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gfx_rom_arbiter
//
// Scoreboard bench for gfx_rom_arbiter. Expected mem_addr values and ack
// data are pushed to queues when a request is raised and popped when the
// DUT raises mem_req or an ack. A behavioural memory answers mem_req after
// mem_lat observed cycles. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gfx_rom_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        tile_req;
  logic [17:0] tile_addr;
  logic        tile_ack;
  logic [31:0] tile_dout;
  logic        spr_req;
  logic [18:0] spr_addr;
  logic        spr_ack;
  logic [31:0] spr_dout;
  logic        theme_req;
  logic [17:0] theme_addr;
  logic        theme_ack;
  logic [15:0] theme_dout;
  logic        mem_req;
  logic [21:0] mem_addr;
  wire         mem_ready;
  logic [31:0] mem_dout;

  logic        auto_ready;
  logic        manual_ready;
  assign mem_ready = auto_ready | manual_ready;

  always #5 clk_sys = ~clk_sys;

  gfx_rom_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .tile_req       (tile_req),
    .tile_addr      (tile_addr),
    .tile_ack       (tile_ack),
    .tile_dout      (tile_dout),
    .spr_req        (spr_req),
    .spr_addr       (spr_addr),
    .spr_ack        (spr_ack),
    .spr_dout       (spr_dout),
    .theme_req      (theme_req),
    .theme_addr     (theme_addr),
    .theme_ack      (theme_ack),
    .theme_dout     (theme_dout),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_dout       (mem_dout)
  );

  // -------------------------------------------------------------------------
  // Memory model
  // -------------------------------------------------------------------------
  int unsigned mem_lat = 4;
  bit          resp_en = 1'b1;
  logic [31:0] mem_img [logic [21:0]];

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {10'h2A5, a} ^ 32'h0F0F_0000;
  endfunction

  initial begin : responder
    int unsigned cnt;
    cnt        = 0;
    auto_ready = 1'b0;
    mem_dout   = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (auto_ready) begin
        auto_ready = 1'b0;
        cnt        = 0;
      end else if (resp_en && mem_req && !reset) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_dout   = mem_word(mem_addr);
          auto_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_tile_q[$];
  logic [31:0] exp_spr_q[$];
  logic [15:0] exp_theme_q[$];
  logic [21:0] exp_addr_q[$];
  bit          addr_chk_en  = 1'b1;
  logic        prev_mem_req = 1'b0;

  // Advance one cycle and compare every DUT event against the queues.
  task automatic tick();
    logic [31:0] e32;
    logic [15:0] e16;
    logic [21:0] ea;
    @(negedge clk_sys);
    if (tile_ack === 1'b1) begin
      total++;
      if (exp_tile_q.size() == 0) begin
        bad++;
        $display("FAIL tile_ack_unexpected: ack with dout=%h, required no ack", tile_dout);
      end else begin
        e32 = exp_tile_q.pop_front();
        if (tile_dout !== e32) begin
          bad++;
          $display("FAIL tile_dout: got %h, required %h", tile_dout, e32);
        end
      end
    end
    if (spr_ack === 1'b1) begin
      total++;
      if (exp_spr_q.size() == 0) begin
        bad++;
        $display("FAIL spr_ack_unexpected: ack with dout=%h, required no ack", spr_dout);
      end else begin
        e32 = exp_spr_q.pop_front();
        if (spr_dout !== e32) begin
          bad++;
          $display("FAIL spr_dout: got %h, required %h", spr_dout, e32);
        end
      end
    end
    if (theme_ack === 1'b1) begin
      total++;
      if (exp_theme_q.size() == 0) begin
        bad++;
        $display("FAIL theme_ack_unexpected: ack with dout=%h, required no ack", theme_dout);
      end else begin
        e16 = exp_theme_q.pop_front();
        if (theme_dout !== e16) begin
          bad++;
          $display("FAIL theme_dout: got %h, required %h", theme_dout, e16);
        end
      end
    end
    if (addr_chk_en && mem_req === 1'b1 && prev_mem_req !== 1'b1) begin
      total++;
      if (exp_addr_q.size() == 0) begin
        bad++;
        $display("FAIL mem_req_unexpected: mem_addr=%h, required no request", mem_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (mem_addr !== ea) begin
          bad++;
          $display("FAIL mem_addr: got %h, required %h", mem_addr, ea);
        end
      end
    end
    prev_mem_req = mem_req;
  endtask

  function automatic logic ack_of(input int sel);
    case (sel)
      0:       return tile_ack;
      1:       return spr_ack;
      default: return theme_ack;
    endcase
  endfunction

  // Wait for an ack; cycles = -1 when the budget runs out.
  task automatic wait_ack(input int sel, input int budget, output int cycles, output bit saw_req);
    cycles  = -1;
    saw_req = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (mem_req === 1'b1) saw_req = 1'b1;
      if (ack_of(sel) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tile_req       = 1'b0;
    tile_addr      = '0;
    spr_req        = 1'b0;
    spr_addr       = '0;
    theme_req      = 1'b0;
    theme_addr     = '0;
    manual_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({tile_ack, spr_ack, theme_ack, mem_req} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_acks: got %b, required 0000", {tile_ack, spr_ack, theme_ack, mem_req});
    end
    total++;
    if (mem_addr !== 22'h0) begin
      bad++;
      $display("FAIL reset_mem_addr: got %h, required 000000", mem_addr);
    end
    total++;
    if (tile_dout !== 32'h0 || spr_dout !== 32'h0 || theme_dout !== 16'h0) begin
      bad++;
      $display("FAIL reset_douts: got %h %h %h, required all 0", tile_dout, spr_dout, theme_dout);
    end
  endtask

  task automatic test_tile_miss();
    int cyc;
    bit saw;
    mem_img[22'h000010] = 32'hDEADBEEF;
    exp_addr_q.push_back(22'h000010);
    exp_tile_q.push_back(32'hDEADBEEF);
    tile_addr = 18'h00010;
    tile_req  = 1'b1;
    wait_ack(0, 40, cyc, saw);
    tile_req = 1'b0;
    total++;
    if (cyc != 7) begin
      bad++;
      $display("FAIL tile_miss_latency: got %0d cycles, required 7", cyc);
    end
    tick();
    tick();
  endtask

  task automatic test_tile_hit();
    int cyc;
    bit saw;
    exp_tile_q.push_back(32'hDEADBEEF);
    tile_addr = 18'h00010;
    tile_req  = 1'b1;
    wait_ack(0, 10, cyc, saw);
    tile_req = 1'b0;
    total++;
    if (cyc != 1) begin
      bad++;
      $display("FAIL tile_hit_latency: got %0d cycles, required 1", cyc);
    end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL tile_hit_mem_req: got mem_req=1, required 0");
    end
    tick();
  endtask

  // Request held after a hit: ack, gap, ack, gap.
  task automatic test_hit_repeat();
    logic [3:0] pat;
    exp_tile_q.push_back(32'hDEADBEEF);
    exp_tile_q.push_back(32'hDEADBEEF);
    tile_addr = 18'h00010;
    tile_req  = 1'b1;
    pat       = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = {pat[2:0], tile_ack};
    end
    tile_req = 1'b0;
    total++;
    if (pat !== 4'b1010) begin
      bad++;
      $display("FAIL hit_repeat_pattern: got %b, required 1010", pat);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [31:0] w;
    logic [2:0]  pend;
    logic [5:0]  ord;
    tile_addr  = 18'h00123;
    spr_addr   = 19'h00456;
    theme_addr = 18'h00789;
    exp_addr_q.push_back(22'h000123);
    exp_addr_q.push_back(22'h040456);
    exp_addr_q.push_back(22'h0C03C4);
    exp_tile_q.push_back(mem_word(22'h000123));
    exp_spr_q.push_back(mem_word(22'h040456));
    w = mem_word(22'h0C03C4);
    exp_theme_q.push_back(w[31:16]);
    tile_req  = 1'b1;
    spr_req   = 1'b1;
    theme_req = 1'b1;
    pend = 3'b111;
    ord  = '0;
    for (int i = 0; i < 200 && pend != 3'b000; i++) begin
      tick();
      if (tile_ack && pend[0]) begin tile_req  = 1'b0; pend[0] = 1'b0; ord = {ord[3:0], 2'd0}; end
      if (spr_ack && pend[1])  begin spr_req   = 1'b0; pend[1] = 1'b0; ord = {ord[3:0], 2'd1}; end
      if (theme_ack && pend[2]) begin theme_req = 1'b0; pend[2] = 1'b0; ord = {ord[3:0], 2'd2}; end
    end
    tile_req  = 1'b0;
    spr_req   = 1'b0;
    theme_req = 1'b0;
    total++;
    if (pend !== 3'b000) begin
      bad++;
      $display("FAIL priority_timeout: pending %b, required 000", pend);
    end
    total++;
    if (ord !== 6'b00_01_10) begin
      bad++;
      $display("FAIL priority_order: got %b, required 000110 (tile,spr,theme)", ord);
    end
    tick();
  endtask

  task automatic test_theme_halfword();
    int cyc;
    bit saw;
    mem_img[22'h0C0001] = 32'h1234ABCD;
    exp_addr_q.push_back(22'h0C0001);
    exp_theme_q.push_back(16'h1234);
    theme_addr = 18'h00003;
    theme_req  = 1'b1;
    wait_ack(2, 40, cyc, saw);
    theme_req = 1'b0;
    total++;
    if (cyc != 7) begin
      bad++;
      $display("FAIL theme_miss_latency: got %0d cycles, required 7", cyc);
    end
    tick();
    exp_theme_q.push_back(16'hABCD);
    theme_addr = 18'h00002;
    theme_req  = 1'b1;
    wait_ack(2, 10, cyc, saw);
    theme_req = 1'b0;
    total++;
    if (cyc != 1 || saw) begin
      bad++;
      $display("FAIL theme_half_hit: got latency=%0d mem_req_seen=%0d, required 1 and 0", cyc, saw);
    end
    tick();
  endtask

  // Tile and sprite keep missing; theme must win the 9th grant.
  task automatic test_starvation();
    logic [31:0] w;
    int  others;
    bit  theme_done;
    int  cyc;
    bit  saw;
    addr_chk_en = 1'b0;
    tile_addr   = 18'h01000;
    spr_addr    = 19'h02000;
    theme_addr  = 18'h00100;
    exp_tile_q.push_back(mem_word(22'h001000));
    exp_spr_q.push_back(mem_word(22'h042000));
    w = mem_word(22'h0C0080);
    exp_theme_q.push_back(w[15:0]);
    tile_req   = 1'b1;
    spr_req    = 1'b1;
    theme_req  = 1'b1;
    others     = 0;
    theme_done = 1'b0;
    for (int i = 0; i < 400 && !theme_done; i++) begin
      tick();
      if (theme_ack) begin
        theme_done = 1'b1;
        theme_req  = 1'b0;
        tile_req   = 1'b0;
        void'(exp_tile_q.pop_back());
      end else begin
        if (tile_ack) begin
          others++;
          tile_addr = tile_addr + 18'd1;
          exp_tile_q.push_back(mem_word(TILE_W(tile_addr)));
        end
        if (spr_ack) begin
          others++;
          spr_addr = spr_addr + 19'd1;
          exp_spr_q.push_back(mem_word(22'h040000 + {3'd0, spr_addr}));
        end
      end
    end
    total++;
    if (!theme_done) begin
      bad++;
      $display("FAIL starvation_timeout: theme_ack not seen, required within budget");
    end
    total++;
    if (others != 8) begin
      bad++;
      $display("FAIL starvation_grants: got %0d other grants before theme, required 8", others);
    end
    wait_ack(1, 40, cyc, saw);
    spr_req = 1'b0;
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL starvation_spr: spr_ack not seen, required ack");
    end
    tick();
    addr_chk_en  = 1'b1;
    prev_mem_req = mem_req;
  endtask

  function automatic logic [21:0] TILE_W(input logic [17:0] a);
    return 22'h000000 + {4'd0, a};
  endfunction

  task automatic test_download();
    int cyc;
    bit saw;
    bit blocked_ok;
    exp_addr_q.push_back(22'h000010);
    exp_tile_q.push_back(32'hDEADBEEF);
    tile_addr = 18'h00010;
    tile_req  = 1'b1;
    wait_ack(0, 40, cyc, saw);
    tile_req = 1'b0;
    total++;
    if (cyc != 7) begin
      bad++;
      $display("FAIL dl_prefetch_latency: got %0d cycles, required 7", cyc);
    end
    tick();
    ioctl_download = 1'b1;
    tick();
    tick();
    exp_addr_q.push_back(22'h000010);
    exp_tile_q.push_back(32'hDEADBEEF);
    tile_req   = 1'b1;
    blocked_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req !== 1'b0 || tile_ack !== 1'b0) blocked_ok = 1'b0;
    end
    total++;
    if (!blocked_ok) begin
      bad++;
      $display("FAIL dl_grant_blocked: got grant or ack during download, required none");
    end
    ioctl_download = 1'b0;
    wait_ack(0, 40, cyc, saw);
    tile_req = 1'b0;
    total++;
    if (cyc != 7 || !saw) begin
      bad++;
      $display("FAIL dl_refetch: got latency=%0d mem_req_seen=%0d, required 7 and 1", cyc, saw);
    end
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    bit got_req;
    bit quiet;
    resp_en   = 1'b0;
    exp_addr_q.push_back(22'h000200);
    tile_addr = 18'h00200;
    tile_req  = 1'b1;
    got_req   = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      tick();
      if (mem_req === 1'b1) got_req = 1'b1;
    end
    tick();
    tick();
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_wait: got mem_req=%b before reset, required 1", mem_req);
    end
    reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_mem_req: got mem_req=%b, required 0", mem_req);
    end
    tile_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    manual_ready = 1'b1;
    tick();
    manual_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tile_ack !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet || tile_dout !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_stray_ready: got quiet=%0d tile_dout=%h, required 1 and 0", quiet, tile_dout);
    end
    resp_en = 1'b1;
  endtask

  initial begin : main
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tile_req       = 1'b0;
    tile_addr      = '0;
    spr_req        = 1'b0;
    spr_addr       = '0;
    theme_req      = 1'b0;
    theme_addr     = '0;
    manual_ready   = 1'b0;

    test_reset();
    test_tile_miss();
    test_tile_hit();
    test_hit_repeat();
    test_priority();
    test_theme_halfword();
    test_starvation();
    test_download();
    test_reset_mid_transfer();

    total++;
    if (exp_tile_q.size() != 0 || exp_spr_q.size() != 0 ||
        exp_theme_q.size() != 0 || exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left tile=%0d spr=%0d theme=%0d addr=%0d, required all 0",
               exp_tile_q.size(), exp_spr_q.size(), exp_theme_q.size(), exp_addr_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx_rom_arbiter.md
Name: gfx_rom_arbiter

Overview:
- Shares one 32-bit external ROM read port (SDRAM controller side) between three requesters: tile ROM fetch (planes), sprite ROM fetch (sprites), and TMNT theme ROM playback (audio).
- Fixed priority: tiles > sprites > theme. An anti-starvation override protects theme, and a per-requester last-word hit latch skips repeat fetches.
- Sits in the top level between the video/audio requesters and the SDRAM read port.

Parameters:
- TILE_BASE, 22'h000000, word-32 base of tile region in external memory
- SPR_BASE, 22'h040000, word-32 base of sprite region
- THEME_BASE, 22'h0C0000, word-32 base of theme region
- THEME_MAX_WAIT, 8, number of lost grants before theme is forced to highest priority

Ports:
- clk_sys  in  1  system clock, 96 MHz
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  high while ROMs load; invalidates hit latches and blocks new grants
- tile_req  in  1  level request; held with stable tile_addr until tile_ack
- tile_addr  in  18  tile word-32 address
- tile_ack  out  1  one-cycle pulse; tile_dout valid from this cycle on
- tile_dout  out  32  tile data, held until the next tile_ack
- spr_req  in  1  as tile_req
- spr_addr  in  19  sprite word-32 address
- spr_ack  out  1  as tile_ack
- spr_dout  out  32  as tile_dout
- theme_req  in  1  as tile_req
- theme_addr  in  18  theme word-16 address
- theme_ack  out  1  as tile_ack
- theme_dout  out  16  selected halfword: theme_addr[0]=0 gives [15:0], 1 gives [31:16]
- mem_req  out  1  external read request; held until mem_ready
- mem_addr  out  22  external word-32 address
- mem_ready  in  1  one-cycle pulse; mem_dout valid in the same cycle
- mem_dout  in  32  external read data

Behaviour:
- Reset values: all acks, mem_req and mem_addr are 0; all douts are 0; hit-valid flags are 0; theme wait count is 0; FSM is in IDLE.
- Address mapping:
  - tile: mem_addr = TILE_BASE + tile_addr
  - sprite: mem_addr = SPR_BASE + spr_addr
  - theme: mem_addr = THEME_BASE + theme_addr[17:1]
  - Sums are 22-bit and wrap mod 2^22.
- Hit path, per requester, evaluated every cycle:
  - Condition: req=1, valid=1, address equals last fetched address (theme compares addr[17:1]), and that requester is not currently granted.
  - Action: ack pulses the next cycle with the latched data. No memory access and no change to arbitration.
  - After an ack, the requester must drop req or change address within 1 cycle. Otherwise the hit repeats every other cycle: ack, then 1 gap cycle, then ack again.
- FSM states:
  - IDLE → GRANT when any miss request is pending and ioctl_download=0. The winner is registered and mem_addr is set.
  - GRANT: mem_req=1 → WAIT.
  - WAIT: mem_req held until mem_ready=1. On that cycle: capture data into the winner's dout and last-address latch, set its valid flag, drop mem_req → DONE.
  - DONE: winner's ack=1 for this one cycle → IDLE.
  - Miss-to-ack latency is mem latency + 3 cycles.
- Priority among misses: tile > sprite > theme.
  - Exception: when theme wait count ≥ THEME_MAX_WAIT and theme_req=1, theme wins.
  - Theme wait count increments (saturating at 255) each time a grant goes to another requester while theme_req=1 with a miss.
  - It clears when theme is granted or theme_req=0.
- Request withdrawn after grant: the transfer completes, dout and latch update, and ack still pulses.
- ioctl_download rises mid-transfer: the current transfer completes, then all valid flags clear. While ioctl_download=1, valid stays 0 and no new grants are issued.
- Simultaneous hit-ack for one requester and DONE-ack for another: both acks pulse in the same cycle.
- Reset asserted mid-transfer: mem_req drops immediately and the FSM returns to IDLE. A later mem_ready while in IDLE is ignored.

Optional Feature:
- Macro GFXARB_STATS_EN.
- When defined, adds outputs:
  - stat_miss, 3x16 bits: per-requester miss-grant counts
  - stat_hit, 3x16 bits: per-requester hit-ack counts
  - stat_maxlat, 8 bits: maximum req-to-ack cycles seen for tile, saturating
  - All counters clear on reset and saturate at max.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single tile miss, tile_addr=18'h00010, mem latency 4 → mem_addr=22'h000010; tile_ack 7 cycles after tile_req; tile_dout=mem_dout=32'hDEADBEEF.
- Same tile_addr re-requested after ack → tile_ack next cycle; mem_req stays 0; tile_dout still 32'hDEADBEEF.
- tile_req, spr_req, theme_req all raised together, all misses → grants in order tile, sprite, theme; mem_addr sequence 22'h000000+ta, 22'h040000+sa, 22'h0C0000+(tha>>1).
- tile and sprite re-requested with new addresses continuously, theme_req held, THEME_MAX_WAIT=8 → theme granted on the 9th grant at the latest; theme_ack follows.
- theme_addr=18'h00003 with mem_dout=32'h1234ABCD → theme_dout=16'h1234. Then theme_addr=18'h00002 → hit, theme_dout=16'hABCD, no mem_req.
- ioctl_download pulsed after a completed fetch, then the same tile_addr requested → miss; mem_req asserted again. Reset asserted during WAIT → mem_req=0 next edge; no ack.
